// File: rtl/fft_stream_pkg.sv
// Shared types and helpers for the FFT frame serializer.
// Optional bit-reversed read order is enabled by FFT_SERIALIZER_BITREV_EN.
package fft_stream_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    PRESENT   = 2'd2
  } ser_state_t;

  // Width of a word index within an n-word frame (n is a power of two, >= 2).
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  // Reverse the low w bits of v; bits above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < w; i++) begin
      r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_serializer_if.sv
// Frame-in / word-out bus of the FFT frame serializer.
// The slave modport is the serializer's view; master is the surrounding system.
interface fft_frame_serializer_if
  import fft_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 32
);
  localparam int IDX_W = idx_w(N);

  logic [N-1:0][WIDTH-1:0] frame_in;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    sample_tick;
  logic [WIDTH-1:0]        out_data;
  logic [IDX_W-1:0]        out_index;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    missed_tick;

  modport slave (
    input  frame_in, frame_valid, sample_tick, out_ready,
    output frame_ready, out_data, out_index, out_valid, out_last, missed_tick
  );

  modport master (
    output frame_in, frame_valid, sample_tick, out_ready,
    input  frame_ready, out_data, out_index, out_valid, out_last, missed_tick
  );

endinterface

// File: rtl/frame_slot_buffer.sv
// Two-slot frame store: whole-frame write port and a combinational word read port.
module frame_slot_buffer
  import fft_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 32
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [N-1:0][WIDTH-1:0]   wr_frame,
  input  logic                      rd_sel,
  input  logic [idx_w(N)-1:0]       rd_idx,
  output logic [WIDTH-1:0]          rd_data
);

  logic [N-1:0][WIDTH-1:0] slot_r [2];

  // Slot contents are pure data; validity lives in the owner's pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot_r[wr_sel] <= wr_frame;
    end
  end

  assign rd_data = slot_r[rd_sel][rd_idx];

endmodule

// File: rtl/fft_frame_serializer.sv
// Ping-pong FFT frame serializer: accepts whole frames, emits one word per sample tick.
// Define FFT_SERIALIZER_BITREV_EN to read each frame in bit-reversed index order.
module fft_frame_serializer
  import fft_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fft_frame_serializer_if.slave  bus
);

  localparam int               IDX_W    = idx_w(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  ser_state_t       state_r;
  ser_state_t       state_nx_s;
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       full_slots_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nx_s;

  logic [WIDTH-1:0] out_data_r;
  logic [IDX_W-1:0] out_index_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             missed_tick_r;

  logic             frame_ready_s;
  logic             accept_s;
  logic             xfer_s;
  logic             other_full_s;
  logic             release_s;
  logic             load_s;
  logic             drop_valid_s;
  logic             missed_s;
  logic [IDX_W-1:0] load_pos_s;
  logic [IDX_W-1:0] load_word_idx_s;
  logic             load_slot_s;
  logic [WIDTH-1:0] rd_data_s;
  logic [WIDTH-1:0] load_word_s;

  assign frame_ready_s = (full_slots_r < 2'd2);
  assign accept_s      = bus.frame_valid && frame_ready_s;
  assign xfer_s        = out_valid_r && bus.out_ready;
  // A frame landing in the same cycle the current one releases counts as waiting.
  assign other_full_s  = (full_slots_r == 2'd2) || accept_s;

`ifdef FFT_SERIALIZER_BITREV_EN
  assign load_word_idx_s = IDX_W'(bitrev(32'(load_pos_s), IDX_W));
`else
  assign load_word_idx_s = load_pos_s;
`endif

  frame_slot_buffer #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_slots (
    .clk      (clk),
    .wr_en    (accept_s),
    .wr_sel   (wr_ptr_r),
    .wr_frame (bus.frame_in),
    .rd_sel   (load_slot_s),
    .rd_idx   (load_word_idx_s),
    .rd_data  (rd_data_s)
  );

  // The slot being written this cycle is not in the store yet, so take it from the bus.
  assign load_word_s = (accept_s && (wr_ptr_r == load_slot_s)) ?
                       bus.frame_in[load_word_idx_s] : rd_data_s;

  // Next-state and datapath control for the word pacing FSM.
  always_comb begin
    state_nx_s   = state_r;
    idx_nx_s     = idx_r;
    load_pos_s   = idx_r;
    load_slot_s  = rd_ptr_r;
    load_s       = 1'b0;
    drop_valid_s = 1'b0;
    release_s    = 1'b0;
    missed_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (full_slots_r != 2'd0) begin
          if (bus.sample_tick) begin
            load_s     = 1'b1;
            state_nx_s = PRESENT;
          end else begin
            state_nx_s = WAIT_TICK;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT_TICK: begin
        if (bus.sample_tick) begin
          load_s     = 1'b1;
          state_nx_s = PRESENT;
        end else begin
          state_nx_s = WAIT_TICK;
        end
      end
      PRESENT: begin
        if (xfer_s) begin
          if (idx_r != LAST_IDX) begin
            idx_nx_s   = idx_r + IDX_W'(1);
            load_pos_s = idx_r + IDX_W'(1);
            if (bus.sample_tick) begin
              load_s     = 1'b1;
              state_nx_s = PRESENT;
            end else begin
              drop_valid_s = 1'b1;
              state_nx_s   = WAIT_TICK;
            end
          end else begin
            release_s   = 1'b1;
            idx_nx_s    = {IDX_W{1'b0}};
            load_pos_s  = {IDX_W{1'b0}};
            load_slot_s = ~rd_ptr_r;
            if (other_full_s && bus.sample_tick) begin
              load_s     = 1'b1;
              state_nx_s = PRESENT;
            end else if (other_full_s) begin
              drop_valid_s = 1'b1;
              state_nx_s   = WAIT_TICK;
            end else begin
              drop_valid_s = 1'b1;
              state_nx_s   = IDLE;
            end
          end
        end else begin
          // A tick that finds the word still pending is reported and dropped.
          missed_s   = bus.sample_tick;
          state_nx_s = PRESENT;
        end
      end
      default: begin
        drop_valid_s = 1'b1;
        state_nx_s   = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Slot pointers, occupancy and stream position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      full_slots_r <= 2'd0;
      idx_r        <= {IDX_W{1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (release_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      idx_r <= idx_nx_s;
      case ({accept_s, release_s})
        2'b10:   full_slots_r <= full_slots_r + 2'd1;
        2'b01:   full_slots_r <= full_slots_r - 2'd1;
        default: full_slots_r <= full_slots_r;
      endcase
    end
  end

  // Output word registers; held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r    <= {WIDTH{1'b0}};
      out_index_r   <= {IDX_W{1'b0}};
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
      missed_tick_r <= 1'b0;
    end else begin
      missed_tick_r <= missed_s;
      if (load_s) begin
        out_data_r  <= load_word_s;
        out_index_r <= load_word_idx_s;
        out_last_r  <= (load_pos_s == LAST_IDX);
        out_valid_r <= 1'b1;
      end else if (drop_valid_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign bus.frame_ready = frame_ready_s;
  assign bus.out_data    = out_data_r;
  assign bus.out_index   = out_index_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_last    = out_last_r;
  assign bus.missed_tick = missed_tick_r;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Self-checking bench for fft_frame_serializer against a queue-based word-stream model.
// Honours FFT_SERIALIZER_BITREV_EN in the model's expected read order.
module tb_fft_frame_serializer;
  import fft_stream_pkg::*;

  localparam int WIDTH = 32;
  localparam int N     = 32;
  localparam int IDX_W = idx_w(N);

  typedef logic [N-1:0][WIDTH-1:0] frame_t;
  typedef struct {
    logic [WIDTH-1:0] d;
    logic [IDX_W-1:0] i;
    logic             l;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;

  fft_frame_serializer_if #(.WIDTH(WIDTH), .N(N)) bus ();

  fft_frame_serializer #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: words still owed to the consumer, in stream order, plus expected flags.
  word_t q[$];
  logic  m_valid = 1'b0;
  logic  m_miss  = 1'b0;
  logic  m_acc   = 1'b0;
  int    m_held  = 0;

  function automatic int ref_pos(input int p);
`ifdef FFT_SERIALIZER_BITREV_EN
    int r = 0;
    for (int b = 0; b < IDX_W; b++) begin
      if (((p / (1 << b)) % 2) == 1) r += 1 << (IDX_W - 1 - b);
    end
    return r;
`else
    return p;
`endif
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = $urandom();
    return f;
  endfunction

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_miss  = 1'b0;
    m_acc   = 1'b0;
    m_held  = 0;
  endtask

  // Apply one cycle of stimulus, advance the model by the stream rules, step the clock.
  task automatic drive_cycle(input logic tick, input logic rdy, input logic fv, input frame_t f);
    logic  xfer;
    logic  avail;
    word_t w;
    bus.sample_tick = tick;
    bus.out_ready   = rdy;
    bus.frame_valid = fv;
    bus.frame_in    = f;
    xfer  = m_valid && rdy;
    m_acc = fv && (m_held < 2);
    if (xfer) q.delete(0);
    avail  = (q.size() > 0) || (xfer && m_acc);
    m_miss = m_valid && !rdy && tick;
    m_valid = (m_valid && !rdy) || (avail && tick);
    if (m_acc) begin
      for (int p = 0; p < N; p++) begin
        w.i = IDX_W'(ref_pos(p));
        w.d = f[ref_pos(p)];
        w.l = (p == N - 1);
        q.push_back(w);
      end
    end
    m_held = (q.size() + N - 1) / N;
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
    bus.sample_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.frame_in = '0; bus.frame_valid = 1'b0; bus.sample_tick = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if ({bus.out_valid, bus.out_last, bus.missed_tick} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b expected=000", {bus.out_valid, bus.out_last, bus.missed_tick});
    end
    if ({bus.out_data, bus.out_index} !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%0d expected=0/0", bus.out_data, bus.out_index);
    end
    if (bus.frame_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b expected=1", bus.frame_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (bus.frame_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready got=%b expected=1", bus.frame_ready);
    end
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_valid got=%b expected=0", bus.out_valid);
    end
  endtask

  task automatic test_single_frame();
    frame_t f;
    int     words = 0;
    int     lasts = 0;
    for (int i = 0; i < N; i++) f[i] = 32'h100 + i;
    for (int c = 0; c < 400 && !(c > 2 && q.size() == 0 && !m_valid); c++) begin
      if (bus.out_valid === 1'b1) words++;
      if (bus.out_valid === 1'b1 && bus.out_last === 1'b1) lasts++;
      drive_cycle((c % 4) == 3, 1'b1, c == 0, f);
      checks += 3;
      if (bus.out_valid !== m_valid) begin errors++; $display("FAIL single_valid got=%b expected=%b t=%0t", bus.out_valid, m_valid, $time); end
      if (bus.frame_ready !== (m_held < 2)) begin errors++; $display("FAIL single_ready got=%b expected=%b t=%0t", bus.frame_ready, m_held < 2, $time); end
      if (bus.missed_tick !== m_miss) begin errors++; $display("FAIL single_missed got=%b expected=%b t=%0t", bus.missed_tick, m_miss, $time); end
      if (m_valid && q.size() > 0) begin
        checks++;
        if ({bus.out_data, bus.out_index, bus.out_last} !== {q[0].d, q[0].i, q[0].l})
          begin errors++; $display("FAIL single_word got=%h/%0d/%b expected=%h/%0d/%b", bus.out_data, bus.out_index, bus.out_last, q[0].d, q[0].i, q[0].l); end
      end
    end
    checks += 2;
    if (words != N) begin errors++; $display("FAIL single_count got=%0d expected=%0d", words, N); end
    if (lasts != 1) begin errors++; $display("FAIL single_last_count got=%0d expected=1", lasts); end
  endtask

  task automatic test_back_to_back();
    frame_t fr [3];
    int     k = 0;
    for (int i = 0; i < 3; i++) fr[i] = rand_frame();
    for (int c = 0; c < 800 && !(k == 3 && q.size() == 0 && !m_valid); c++) begin
      drive_cycle((c >= 8) && (c % 2 == 0), 1'b1, k < 3, fr[(k < 3) ? k : 2]);
      if (m_acc) k++;
      checks += 3;
      if (bus.out_valid !== m_valid) begin errors++; $display("FAIL b2b_valid got=%b expected=%b t=%0t", bus.out_valid, m_valid, $time); end
      if (bus.frame_ready !== (m_held < 2)) begin errors++; $display("FAIL b2b_ready got=%b expected=%b t=%0t", bus.frame_ready, m_held < 2, $time); end
      if (bus.missed_tick !== m_miss) begin errors++; $display("FAIL b2b_missed got=%b expected=%b t=%0t", bus.missed_tick, m_miss, $time); end
      if (m_valid && q.size() > 0) begin
        checks++;
        if ({bus.out_data, bus.out_index, bus.out_last} !== {q[0].d, q[0].i, q[0].l})
          begin errors++; $display("FAIL b2b_word got=%h/%0d/%b expected=%h/%0d/%b", bus.out_data, bus.out_index, bus.out_last, q[0].d, q[0].i, q[0].l); end
      end
    end
    checks++;
    if (k != 3) begin errors++; $display("FAIL b2b_accepts got=%0d expected=3", k); end
  endtask

  task automatic test_stall();
    frame_t f;
    int     s = -1;
    int     misses = 0;
    f = rand_frame();
    for (int c = 0; c < 400 && !(c > 2 && q.size() == 0 && !m_valid); c++) begin
      if (s < 0 && m_valid && q.size() < N - 3) s = 0;
      if (s >= 0 && s < 8) begin
        drive_cycle(s == 2 || s == 5, 1'b0, 1'b0, f);
        s++;
      end else begin
        drive_cycle(c % 2 == 0, 1'b1, c == 0, f);
      end
      if (bus.missed_tick === 1'b1) misses++;
      checks += 3;
      if (bus.out_valid !== m_valid) begin errors++; $display("FAIL stall_valid got=%b expected=%b t=%0t", bus.out_valid, m_valid, $time); end
      if (bus.frame_ready !== (m_held < 2)) begin errors++; $display("FAIL stall_ready got=%b expected=%b t=%0t", bus.frame_ready, m_held < 2, $time); end
      if (bus.missed_tick !== m_miss) begin errors++; $display("FAIL stall_missed got=%b expected=%b t=%0t", bus.missed_tick, m_miss, $time); end
      if (m_valid && q.size() > 0) begin
        checks++;
        if ({bus.out_data, bus.out_index, bus.out_last} !== {q[0].d, q[0].i, q[0].l})
          begin errors++; $display("FAIL stall_word got=%h/%0d/%b expected=%h/%0d/%b", bus.out_data, bus.out_index, bus.out_last, q[0].d, q[0].i, q[0].l); end
      end
    end
    checks++;
    if (misses != 2) begin errors++; $display("FAIL stall_miss_count got=%0d expected=2", misses); end
  endtask

  task automatic test_mid_reset();
    frame_t f;
    int     words = 0;
    f = rand_frame();
    for (int c = 0; c < 200 && words < 10; c++) begin
      if (bus.out_valid === 1'b1) words++;
      drive_cycle(c % 2 == 0, 1'b1, c == 0, f);
    end
    checks++;
    if (words != 10) begin errors++; $display("FAIL midrst_reach got=%0d expected=10", words); end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks += 2;
    if ({bus.out_valid, bus.out_last, bus.missed_tick, bus.out_data, bus.out_index} !== '0) begin
      errors++; $display("FAIL midrst_async got=%b/%b/%b/%h/%0d expected=all zero", bus.out_valid, bus.out_last, bus.missed_tick, bus.out_data, bus.out_index);
    end
    if (bus.frame_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b expected=1", bus.frame_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 40; c++) begin
      drive_cycle(c % 2 == 0, 1'b1, 1'b0, f);
      checks += 3;
      if (bus.out_valid !== m_valid) begin errors++; $display("FAIL midrst_valid got=%b expected=%b t=%0t", bus.out_valid, m_valid, $time); end
      if (bus.frame_ready !== (m_held < 2)) begin errors++; $display("FAIL midrst_ready2 got=%b expected=%b t=%0t", bus.frame_ready, m_held < 2, $time); end
      if (bus.out_last !== 1'b0) begin errors++; $display("FAIL midrst_last got=%b expected=0 t=%0t", bus.out_last, $time); end
    end
  endtask

  task automatic test_tick_release_accept();
    frame_t fa;
    frame_t fb;
    logic   done = 1'b0;
    fa = rand_frame();
    fb = rand_frame();
    for (int c = 0; c < 400 && !(done && q.size() == 0 && !m_valid); c++) begin
      if (!done && m_valid && q.size() == 1) begin
        drive_cycle(1'b1, 1'b1, 1'b1, fb);
        done = 1'b1;
        checks += 3;
        if (m_acc !== 1'b1) begin errors++; $display("FAIL tra_accept got=%b expected=1", m_acc); end
        if (bus.frame_ready !== 1'b1) begin errors++; $display("FAIL tra_ready got=%b expected=1", bus.frame_ready); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL tra_next_valid got=%b expected=1", bus.out_valid); end
      end else begin
        drive_cycle(c % 2 == 0, 1'b1, c == 0, fa);
      end
      checks += 3;
      if (bus.out_valid !== m_valid) begin errors++; $display("FAIL tra_valid got=%b expected=%b t=%0t", bus.out_valid, m_valid, $time); end
      if (bus.frame_ready !== (m_held < 2)) begin errors++; $display("FAIL tra_ready2 got=%b expected=%b t=%0t", bus.frame_ready, m_held < 2, $time); end
      if (bus.missed_tick !== m_miss) begin errors++; $display("FAIL tra_missed got=%b expected=%b t=%0t", bus.missed_tick, m_miss, $time); end
      if (m_valid && q.size() > 0) begin
        checks++;
        if ({bus.out_data, bus.out_index, bus.out_last} !== {q[0].d, q[0].i, q[0].l})
          begin errors++; $display("FAIL tra_word got=%h/%0d/%b expected=%h/%0d/%b", bus.out_data, bus.out_index, bus.out_last, q[0].d, q[0].i, q[0].l); end
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL tra_reached got=%b expected=1", done); end
  endtask

  task automatic test_random();
    frame_t f;
    logic   pend = 1'b0;
    f = rand_frame();
    for (int c = 0; c < 2500; c++) begin
      if (!pend && $urandom_range(0, 19) == 0) begin
        f = rand_frame();
        pend = 1'b1;
      end
      drive_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, pend, f);
      if (m_acc) pend = 1'b0;
      checks += 3;
      if (bus.out_valid !== m_valid) begin errors++; $display("FAIL rand_valid got=%b expected=%b t=%0t", bus.out_valid, m_valid, $time); end
      if (bus.frame_ready !== (m_held < 2)) begin errors++; $display("FAIL rand_ready got=%b expected=%b t=%0t", bus.frame_ready, m_held < 2, $time); end
      if (bus.missed_tick !== m_miss) begin errors++; $display("FAIL rand_missed got=%b expected=%b t=%0t", bus.missed_tick, m_miss, $time); end
      if (m_valid && q.size() > 0) begin
        checks++;
        if ({bus.out_data, bus.out_index, bus.out_last} !== {q[0].d, q[0].i, q[0].l})
          begin errors++; $display("FAIL rand_word got=%h/%0d/%b expected=%h/%0d/%b", bus.out_data, bus.out_index, bus.out_last, q[0].d, q[0].i, q[0].l); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_tick_release_accept();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
